// File: rtl/board_row_clear_ctrl.sv
// Line-clear sequencer for one player's board RAM: scans rows bottom-up, drops full rows,
// compacts survivors downward, zero-fills the top, and arbitrates the RAM ports.
module board_row_clear_ctrl #(
    parameter int unsigned COLS   = 10,
    parameter int unsigned ROWS   = 20,
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    output logic              BUSY,
    output logic              DONE,
    output logic [4:0]        LINES_CLEARED,
    input  logic              CPU_WREN,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic [DATA_W-1:0] CPU_WDATA,
    input  logic [3:0]        CPU_BYTEEN,
    output logic              CPU_WAIT,
    input  logic [ADDR_W-1:0] DISP_RDADDR,
    output logic [ADDR_W-1:0] RAM_RDADDR,
    input  logic [DATA_W-1:0] RAM_Q,
    output logic [ADDR_W-1:0] RAM_WRADDR,
    output logic [DATA_W-1:0] RAM_WDATA,
    output logic [3:0]        RAM_BYTEEN,
    output logic              RAM_WREN
);

    localparam int unsigned RowW = $clog2(ROWS);
    localparam int unsigned ColW = $clog2(COLS + 1);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StEval,
        StWrite,
        StFill,
        StFin
    } state_e;

    state_e              state_q, state_d;
    logic [RowW-1:0]     src_q, src_d;
    logic [RowW-1:0]     dst_q, dst_d;
    logic [ColW-1:0]     col_q, col_d;
    logic [4:0]          cleared_q, cleared_d;
    logic [4:0]          lines_q, lines_d;
    logic [ADDR_W-1:0]   fill_q, fill_d;
    logic [DATA_W-1:0]   buf_q [COLS];
    logic [DATA_W-1:0]   buf_d [COLS];

    logic                row_full;
    logic                leave_row;
    logic [ADDR_W-1:0]   src_base;
    logic [ADDR_W-1:0]   dst_base;
    logic [ADDR_W-1:0]   fill_end;
    logic [DATA_W-1:0]   buf_sel;

    assign src_base = ADDR_W'(src_q) * ADDR_W'(COLS);
    assign dst_base = ADDR_W'(dst_q) * ADDR_W'(COLS);
    assign fill_end = ADDR_W'(cleared_q) * ADDR_W'(COLS);

    always_comb begin
        row_full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (buf_q[c][3:0] == 4'h0) begin
                row_full = 1'b0;
            end
        end
    end

    always_comb begin
        buf_sel = '0;
        for (int c = 0; c < COLS; c++) begin
            if (col_q == ColW'(c)) begin
                buf_sel = buf_q[c];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        col_d     = col_q;
        cleared_d = cleared_q;
        lines_d   = lines_q;
        fill_d    = fill_q;
        buf_d     = buf_q;
        leave_row = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (START) begin
                    src_d     = RowW'(ROWS - 1);
                    dst_d     = RowW'(ROWS - 1);
                    col_d     = '0;
                    cleared_d = '0;
                    lines_d   = '0;
                    state_d   = StRead;
                end
            end
            StRead: begin
                // RAM_Q carries the cell addressed one cycle earlier
                for (int c = 0; c < COLS; c++) begin
                    if (col_q == ColW'(c + 1)) begin
                        buf_d[c] = RAM_Q;
                    end
                end
                if (col_q == ColW'(COLS)) begin
                    col_d   = '0;
                    state_d = StEval;
                end else begin
                    col_d = col_q + ColW'(1);
                end
            end
            StEval: begin
                if (row_full) begin
                    cleared_d = cleared_q + 5'd1;
                    leave_row = 1'b1;
                end else if (dst_q == src_q) begin
                    dst_d     = dst_q - RowW'(1);
                    leave_row = 1'b1;
                end else begin
                    col_d   = '0;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (col_q == ColW'(COLS - 1)) begin
                    dst_d     = dst_q - RowW'(1);
                    leave_row = 1'b1;
                end else begin
                    col_d = col_q + ColW'(1);
                end
            end
            StFill: begin
                if (fill_q == fill_end - ADDR_W'(1)) begin
                    state_d = StFin;
                end else begin
                    fill_d = fill_q + ADDR_W'(1);
                end
            end
            StFin: begin
                lines_d = cleared_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Row finished: either step up to the next source row or start the top fill
        if (leave_row) begin
            col_d = '0;
            if (src_q == '0) begin
                fill_d  = '0;
                state_d = (cleared_d == 5'd0) ? StFin : StFill;
            end else begin
                src_d   = src_q - RowW'(1);
                state_d = StRead;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= StIdle;
            src_q     <= '0;
            dst_q     <= '0;
            col_q     <= '0;
            cleared_q <= '0;
            lines_q   <= '0;
            fill_q    <= '0;
            for (int c = 0; c < COLS; c++) begin
                buf_q[c] <= '0;
            end
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            col_q     <= col_d;
            cleared_q <= cleared_d;
            lines_q   <= lines_d;
            fill_q    <= fill_d;
            buf_q     <= buf_d;
        end
    end

    assign BUSY          = (state_q != StIdle);
    assign DONE          = (state_q == StFin);
    assign LINES_CLEARED = DONE ? cleared_q : lines_q;
    assign CPU_WAIT      = BUSY & CPU_WREN;

    // Port muxes decode the registered state only, so reset frees the RAM immediately
    always_comb begin
        RAM_RDADDR = src_base + ADDR_W'(col_q);
        RAM_WREN   = 1'b0;
        RAM_WRADDR = '0;
        RAM_WDATA  = '0;
        RAM_BYTEEN = 4'b0000;

        unique case (state_q)
            StIdle: begin
                RAM_RDADDR = DISP_RDADDR;
                RAM_WREN   = CPU_WREN;
                RAM_WRADDR = CPU_ADDR;
                RAM_WDATA  = CPU_WDATA;
                RAM_BYTEEN = CPU_BYTEEN;
            end
            StWrite: begin
                RAM_WREN   = 1'b1;
                RAM_WRADDR = dst_base + ADDR_W'(col_q);
                RAM_WDATA  = buf_sel;
                RAM_BYTEEN = 4'b1111;
            end
            StFill: begin
                RAM_WREN   = 1'b1;
                RAM_WRADDR = fill_q;
                RAM_WDATA  = '0;
                RAM_BYTEEN = 4'b1111;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_board_row_clear_ctrl.sv
// Randomised bench for board_row_clear_ctrl: a behavioural RAM, a row-list reference model
// of line clearing, and directed cases for port arbitration, restart and mid-pass reset.
module tb_board_row_clear_ctrl;

    localparam int COLS   = 10;
    localparam int ROWS   = 20;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int CELLS  = COLS * ROWS;

    logic              CLK = 1'b0;
    logic              RESET = 1'b0;
    logic              START = 1'b0;
    logic              BUSY;
    logic              DONE;
    logic [4:0]        LINES_CLEARED;
    logic              CPU_WREN = 1'b0;
    logic [ADDR_W-1:0] CPU_ADDR = '0;
    logic [DATA_W-1:0] CPU_WDATA = '0;
    logic [3:0]        CPU_BYTEEN = '0;
    logic              CPU_WAIT;
    logic [ADDR_W-1:0] DISP_RDADDR = 11'd37;
    logic [ADDR_W-1:0] RAM_RDADDR;
    logic [DATA_W-1:0] RAM_Q = '0;
    logic [ADDR_W-1:0] RAM_WRADDR;
    logic [DATA_W-1:0] RAM_WDATA;
    logic [3:0]        RAM_BYTEEN;
    logic              RAM_WREN;

    board_row_clear_ctrl #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .START         (START),
        .BUSY          (BUSY),
        .DONE          (DONE),
        .LINES_CLEARED (LINES_CLEARED),
        .CPU_WREN      (CPU_WREN),
        .CPU_ADDR      (CPU_ADDR),
        .CPU_WDATA     (CPU_WDATA),
        .CPU_BYTEEN    (CPU_BYTEEN),
        .CPU_WAIT      (CPU_WAIT),
        .DISP_RDADDR   (DISP_RDADDR),
        .RAM_RDADDR    (RAM_RDADDR),
        .RAM_Q         (RAM_Q),
        .RAM_WRADDR    (RAM_WRADDR),
        .RAM_WDATA     (RAM_WDATA),
        .RAM_BYTEEN    (RAM_BYTEEN),
        .RAM_WREN      (RAM_WREN)
    );

    always #10 CLK = ~CLK;

    // Board RAM: byte-enabled write, one-cycle registered read
    logic [31:0] mem [0:2047];
    logic [31:0] wtmp;
    always @(posedge CLK) begin
        if (RAM_WREN) begin
            wtmp = mem[RAM_WRADDR];
            for (int b = 0; b < 4; b++) begin
                if (RAM_BYTEEN[b]) wtmp[8*b +: 8] = RAM_WDATA[8*b +: 8];
            end
            mem[RAM_WRADDR] <= wtmp;
        end
        RAM_Q <= mem[RAM_RDADDR];
    end

    int n_checks = 0;
    int n_errors = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int wr_cnt   = 0;
    int wait_err = 0;
    int pass_err = 0;
    logic [4:0] done_lines = '0;

    always @(negedge CLK) begin
        if (BUSY) busy_cnt++;
        if (DONE) begin
            done_cnt++;
            done_lines = LINES_CLEARED;
        end
        if (BUSY && RAM_WREN) wr_cnt++;
        if (CPU_WAIT !== (BUSY & CPU_WREN)) wait_err++;
        if (!BUSY && (RAM_RDADDR !== DISP_RDADDR || RAM_WREN !== CPU_WREN ||
            (CPU_WREN && (RAM_WRADDR !== CPU_ADDR || RAM_WDATA !== CPU_WDATA ||
                          RAM_BYTEEN !== CPU_BYTEEN)))) pass_err++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [31:0] board   [ROWS][COLS];
    logic [31:0] exp_mem [CELLS];

    function automatic bit is_full(input int r);
        for (int c = 0; c < COLS; c++) begin
            if (board[r][c][3:0] == 4'h0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Surviving rows keep their order and land at the bottom; a survivor costs a row
    // write only once some full row below it has been dropped.
    task automatic build_expect(output int exp_lines, output int exp_busy, output int exp_wr);
        int dst = ROWS - 1;
        int cl = 0;
        int cp = 0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (is_full(r)) begin
                cl++;
            end else begin
                if (cl > 0) cp++;
                for (int c = 0; c < COLS; c++) exp_mem[dst*COLS + c] = board[r][c];
                dst--;
            end
        end
        for (int r = dst; r >= 0; r--) begin
            for (int c = 0; c < COLS; c++) exp_mem[r*COLS + c] = 32'h0;
        end
        exp_lines = cl;
        exp_wr    = (cp + cl) * COLS;
        exp_busy  = ROWS * (COLS + 2) + exp_wr + 1;
    endtask

    task automatic clear_board();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) board[r][c] = 32'h0;
    endtask

    function automatic logic [31:0] rnd_cell(input bit filled);
        logic [31:0] rnd;
        logic [3:0]  nib;
        rnd = $urandom;
        nib = filled ? 4'($urandom_range(1, 15)) : 4'h0;
        return {rnd[31:4], nib};
    endfunction

    task automatic random_board();
        int kind;
        int hole;
        for (int r = 0; r < ROWS; r++) begin
            kind = $urandom_range(0, 3);
            hole = $urandom_range(0, COLS - 1);
            for (int c = 0; c < COLS; c++) begin
                case (kind)
                    0: board[r][c] = rnd_cell(1'b1);
                    1: board[r][c] = rnd_cell(1'b0);
                    2: board[r][c] = rnd_cell($urandom_range(0, 1) == 1);
                    default: board[r][c] = rnd_cell(c != hole);
                endcase
            end
        end
    endtask

    // Loading goes through the CPU passthrough, which also exercises it in IDLE
    task automatic load_board();
        for (int a = 0; a < CELLS; a++) begin
            @(negedge CLK); #1;
            CPU_WREN    = 1'b1;
            CPU_ADDR    = ADDR_W'(a);
            CPU_WDATA   = board[a / COLS][a % COLS];
            CPU_BYTEEN  = 4'hF;
            DISP_RDADDR = ADDR_W'($urandom);
        end
        @(negedge CLK); #1;
        CPU_WREN = 1'b0;
    endtask

    task automatic run_pass(input string tag, input int restart_at, input bit cpu_hold);
        int el, eb, ew;
        int b0, d0, w0, we0, pe0;
        int n;
        int mism;
        bit timeout;
        build_expect(el, eb, ew);
        b0 = busy_cnt; d0 = done_cnt; w0 = wr_cnt; we0 = wait_err; pe0 = pass_err;
        @(negedge CLK); #1;
        START = 1'b1;
        @(negedge CLK); #1;
        START = 1'b0;
        check_eq({tag, "_busy_rise"}, 32'(BUSY), 32'd1);
        if (cpu_hold) begin
            CPU_WREN   = 1'b1;
            CPU_ADDR   = 11'd5;
            CPU_WDATA  = 32'hA5A5_0007;
            CPU_BYTEEN = 4'hF;
        end
        n = 0;
        timeout = 1'b1;
        while (n < 2000) begin
            if (!BUSY) begin
                timeout = 1'b0;
                break;
            end
            START = (restart_at > 0 && n == restart_at);
            if (cpu_hold && n == 20) check_eq({tag, "_cpu_wait_busy"}, 32'(CPU_WAIT), 32'd1);
            @(negedge CLK); #1;
            n++;
        end
        START = 1'b0;
        check_eq({tag, "_timeout"}, 32'(timeout), 32'd0);
        if (cpu_hold) begin
            check_eq({tag, "_cpu_wait_idle"}, 32'(CPU_WAIT), 32'd0);
            check_eq({tag, "_cpu_wren_idle"}, 32'(RAM_WREN), 32'd1);
            check_eq({tag, "_cpu_addr_idle"}, 32'(RAM_WRADDR), 32'd5);
            exp_mem[5] = 32'hA5A5_0007;
            @(negedge CLK); #1;
            CPU_WREN = 1'b0;
        end
        check_eq({tag, "_busy_cycles"}, busy_cnt - b0, eb);
        check_eq({tag, "_done_pulses"}, done_cnt - d0, 32'd1);
        check_eq({tag, "_done_lines"}, 32'(done_lines), el);
        check_eq({tag, "_lines_idle"}, 32'(LINES_CLEARED), el);
        check_eq({tag, "_writes"}, wr_cnt - w0, ew);
        check_eq({tag, "_cpu_wait_rule"}, wait_err - we0, 32'd0);
        check_eq({tag, "_idle_passthru"}, pass_err - pe0, 32'd0);
        mism = 0;
        for (int a = 0; a < CELLS; a++) begin
            if (mem[a] !== exp_mem[a]) begin
                if (mism == 0) $display("first bad cell %0d: got %0h want %0h", a, mem[a], exp_mem[a]);
                mism++;
            end
        end
        check_eq({tag, "_cells"}, mism, 32'd0);
    endtask

    initial begin
        int n;
        bit timeout;
        #5;
        check_eq("rst_busy", 32'(BUSY), 32'd0);
        check_eq("rst_done", 32'(DONE), 32'd0);
        check_eq("rst_lines", 32'(LINES_CLEARED), 32'd0);
        check_eq("rst_cpu_wait", 32'(CPU_WAIT), 32'd0);
        check_eq("rst_wren", 32'(RAM_WREN), 32'd0);
        check_eq("rst_rdaddr", 32'(RAM_RDADDR), 32'd37);
        @(negedge CLK); #1;
        RESET = 1'b1;

        clear_board();
        load_board();
        run_pass("empty", 0, 1'b0);

        clear_board();
        for (int c = 0; c < COLS; c++) board[19][c] = 32'h1;
        board[18][0] = 32'h2;
        load_board();
        run_pass("one_line", 0, 1'b0);

        clear_board();
        for (int c = 0; c < COLS; c++) begin
            board[19][c] = 32'h1;
            board[17][c] = 32'h1;
        end
        for (int c = 0; c < 5; c++) board[18][c] = 32'h3;
        board[16][9] = 32'h5;
        load_board();
        run_pass("two_lines", 0, 1'b0);

        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) board[r][c] = rnd_cell(1'b1);
        load_board();
        run_pass("all_full", 0, 1'b0);

        clear_board();
        load_board();
        run_pass("cpu_hold", 0, 1'b1);

        random_board();
        load_board();
        run_pass("restart", 50, 1'b0);

        random_board();
        for (int c = 0; c < COLS; c++) board[19][c] = rnd_cell(1'b1);
        load_board();
        @(negedge CLK); #1;
        START = 1'b1;
        @(negedge CLK); #1;
        START = 1'b0;
        n = 0;
        timeout = 1'b1;
        while (n < 1000) begin
            if (BUSY && RAM_WREN) begin
                timeout = 1'b0;
                break;
            end
            @(negedge CLK); #1;
            n++;
        end
        check_eq("rstw_reach_write", 32'(timeout), 32'd0);
        RESET = 1'b0;
        #1;
        check_eq("rstw_wren", 32'(RAM_WREN), 32'd0);
        check_eq("rstw_busy", 32'(BUSY), 32'd0);
        check_eq("rstw_done", 32'(DONE), 32'd0);
        @(negedge CLK); #1;
        RESET = 1'b1;
        random_board();
        load_board();
        run_pass("after_rst", 0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            random_board();
            load_board();
            run_pass($sformatf("rand%0d", i), 0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
